mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between two requesters: the IF stage (instruction read) and the MEM stage (data read/write).
- Sits between the pipeline stages and the memory macro.
- Sequences each access with an issue/wait/respond FSM.
- Drives stall signals that freeze the requesting stage until its access completes.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_lat_timer.sv | 30 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the unified-memory port arbiter.
// State encoding, owner ids and internal counter width.
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  localparam int CNT_W = 4;

  // Fetches always read a full word.
  localparam logic [1:0] BYTESEL_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_lat_timer.sv
// mem_arb_lat_timer: load/decrement down-counter for memory latency.
// expired is high in the last wait cycle, when read data is valid.
module mem_arb_lat_timer
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic load,
  input  logic dec,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Load on issue, count down through the wait window.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(MEM_LAT);
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: IF/MEM sharing of one fixed-latency memory port.
// MEM_ARB_PERF_CNT_EN enables the Perf_Conflicts contention counter.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  output logic        IF_Ack,
  output logic [31:0] IF_RData,
  input  logic        D_Req,
  input  logic        D_Write,
  input  logic [31:0] D_Addr,
  input  logic [31:0] D_WData,
  input  logic [1:0]  D_ByteSel,
  output logic        D_Ack,
  output logic [31:0] D_RData,
  output logic        Mem_En,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic [1:0]  Mem_ByteSel,
  input  logic [31:0] Mem_RData,
  output logic        Stall_IF,
  output logic        Stall_MEM,
  output logic [15:0] Perf_Conflicts
);

  logic [1:0]       state;
  logic             owner;
  logic             isWrite;
  logic [CNT_W-1:0] starveCnt;
  logic             timerExp;
  logic             starved;
  logic             dWins;

  assign starved = starveCnt == CNT_W'(STARVE_MAX);
  assign dWins   = D_Req & ~(IF_Req & starved);

  assign Mem_En    = (state == ISSUE);
  assign Mem_We    = Mem_En & (owner == OWNER_D) & isWrite;
  assign Stall_IF  = IF_Req & ~IF_Ack;
  assign Stall_MEM = D_Req & ~D_Ack;

  mem_arb_lat_timer #(
    .MEM_LAT(MEM_LAT)
  ) latTimer (
    .Clock  (Clock),
    .Reset  (Reset),
    .load   (state == ISSUE),
    .dec    (state == WAIT),
    .expired(timerExp)
  );

  // Access sequencer: arbitrate, issue, wait out latency, respond.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      owner       <= OWNER_IF;
      isWrite     <= 1'b0;
      starveCnt   <= '0;
      IF_Ack      <= 1'b0;
      D_Ack       <= 1'b0;
      IF_RData    <= '0;
      D_RData     <= '0;
      Mem_Addr    <= '0;
      Mem_WData   <= '0;
      Mem_ByteSel <= '0;
    end else begin
      IF_Ack <= 1'b0;
      D_Ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (IF_Req || D_Req) begin
            state <= ISSUE;
            if (dWins) begin
              owner       <= OWNER_D;
              isWrite     <= D_Write;
              Mem_Addr    <= D_Addr;
              Mem_WData   <= D_WData;
              Mem_ByteSel <= D_ByteSel;
              if (IF_Req) starveCnt <= starveCnt + 1'b1;
            end else begin
              owner       <= OWNER_IF;
              isWrite     <= 1'b0;
              Mem_Addr    <= IF_Addr;
              Mem_WData   <= '0;
              Mem_ByteSel <= BYTESEL_WORD;
              starveCnt   <= '0;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (timerExp) begin
            state <= RESP;
            if (owner == OWNER_D) begin
              D_Ack <= 1'b1;
              if (!isWrite) D_RData <= Mem_RData;
            end else begin
              IF_Ack   <= 1'b1;
              IF_RData <= Mem_RData;
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] perfCnt;

  // Saturating count of idle cycles with both requesters waiting.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      perfCnt <= '0;
    end else if (state == IDLE && IF_Req && D_Req
                 && perfCnt != 16'hFFFF) begin
      perfCnt <= perfCnt + 1'b1;
    end
  end

  assign Perf_Conflicts = perfCnt;
`else
  assign Perf_Conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the arbiter.
// Memory is modelled as a fixed function of address with latency.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        IF_Req = 1'b0;
  logic [31:0] IF_Addr = '0;
  logic        IF_Ack;
  logic [31:0] IF_RData;
  logic        D_Req = 1'b0;
  logic        D_Write = 1'b0;
  logic [31:0] D_Addr = '0;
  logic [31:0] D_WData = '0;
  logic [1:0]  D_ByteSel = '0;
  logic        D_Ack;
  logic [31:0] D_RData;
  logic        Mem_En;
  logic        Mem_We;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [1:0]  Mem_ByteSel;
  logic [31:0] Mem_RData;
  logic        Stall_IF;
  logic        Stall_MEM;
  logic [15:0] Perf_Conflicts;

  int errors = 0;
  int checks = 0;

  int          respCnt = 0;
  logic [31:0] respAddr = '0;
  logic [31:0] garb = '0;

  always #5 Clock = ~Clock;

  mem_port_arbiter #(
    .MEM_LAT(MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr),
    .IF_Ack(IF_Ack), .IF_RData(IF_RData),
    .D_Req(D_Req), .D_Write(D_Write),
    .D_Addr(D_Addr), .D_WData(D_WData),
    .D_ByteSel(D_ByteSel), .D_Ack(D_Ack),
    .D_RData(D_RData), .Mem_En(Mem_En),
    .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_ByteSel(Mem_ByteSel),
    .Mem_RData(Mem_RData), .Stall_IF(Stall_IF),
    .Stall_MEM(Stall_MEM),
    .Perf_Conflicts(Perf_Conflicts)
  );

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h2002_000A;
  endfunction

  // Memory macro: data valid MEM_LAT cycles after issue, junk otherwise.
  always @(posedge Clock) begin
    garb <= $urandom;
    if (Mem_En && !Mem_We) begin
      respCnt  <= MEM_LAT;
      respAddr <= Mem_Addr;
    end else if (respCnt != 0) begin
      respCnt <= respCnt - 1;
    end
  end

  assign Mem_RData = (respCnt == 1) ? memFn(respAddr) : garb;

  task automatic do_reset;
    Reset = 1'b1;
    IF_Req = 1'b0; IF_Addr = '0;
    D_Req = 1'b0; D_Write = 1'b0; D_Addr = '0;
    D_WData = '0; D_ByteSel = '0;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge Clock);
    checks++;
    if ({IF_Ack, D_Ack, Mem_En, Mem_We, Stall_IF, Stall_MEM} !== 6'b0)
      begin errors++; $display("FAIL reset_flags got=%b exp=0",
        {IF_Ack, D_Ack, Mem_En, Mem_We, Stall_IF, Stall_MEM}); end
    checks++;
    if ({IF_RData, D_RData, Mem_Addr, Mem_WData, Mem_ByteSel} !== '0)
      begin errors++; $display("FAIL reset_data got=%h %h %h %h %h exp=0",
        IF_RData, D_RData, Mem_Addr, Mem_WData, Mem_ByteSel); end
    checks++;
    if (Perf_Conflicts !== 16'd0) begin
      errors++; $display("FAIL reset_perf got=%0d exp=0", Perf_Conflicts);
    end
    next_cycle();
  endtask

  task automatic test_if_read;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin IF_Req = 1'b1; IF_Addr = 32'h40; end
      if (c == 5) IF_Req = 1'b0;
      @(negedge Clock);
      checks++;
      if (IF_Ack !== (c == 4)) begin errors++;
        $display("FAIL ifrd_ack c=%0d got=%b exp=%b", c, IF_Ack, c == 4); end
      checks++;
      if (Mem_En !== (c == 1) || Mem_We !== 1'b0) begin errors++;
        $display("FAIL ifrd_en c=%0d got=%b%b", c, Mem_En, Mem_We); end
      if (c == 1) begin
        checks++;
        if (Mem_Addr !== 32'h40) begin errors++;
          $display("FAIL ifrd_addr got=%h exp=40", Mem_Addr); end
      end
      if (c < 5) begin
        checks++;
        if (Stall_IF !== (c < 4)) begin errors++;
          $display("FAIL ifrd_stall c=%0d got=%b", c, Stall_IF); end
      end
      if (c == 4) begin
        checks++;
        if (IF_RData !== memFn(32'h40)) begin errors++;
          $display("FAIL ifrd_data got=%h exp=%h", IF_RData, memFn(32'h40));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_store;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        D_Req = 1'b1; D_Write = 1'b1; D_Addr = 32'h100;
        D_WData = 32'hDEADBEEF; D_ByteSel = 2'd0;
      end
      if (c == 5) D_Req = 1'b0;
      @(negedge Clock);
      checks++;
      if (D_Ack !== (c == 4)) begin errors++;
        $display("FAIL st_ack c=%0d got=%b exp=%b", c, D_Ack, c == 4); end
      checks++;
      if (Mem_En !== (c == 1) || Mem_We !== (c == 1)) begin errors++;
        $display("FAIL st_en c=%0d got=%b%b", c, Mem_En, Mem_We); end
      if (c == 1) begin
        checks++;
        if ({Mem_Addr, Mem_WData, Mem_ByteSel}
            !== {32'h100, 32'hDEADBEEF, 2'd0}) begin errors++;
          $display("FAIL st_bus got=%h %h %h", Mem_Addr, Mem_WData,
            Mem_ByteSel); end
      end
      if (c < 5) begin
        checks++;
        if (Stall_MEM !== (c < 4)) begin errors++;
          $display("FAIL st_stall c=%0d got=%b", c, Stall_MEM); end
      end
      if (c == 4) begin
        checks++;
        if (D_RData !== 32'h0) begin errors++;
          $display("FAIL st_rdata got=%h exp=0", D_RData); end
      end
      next_cycle();
    end
  endtask

  task automatic test_conflict;
    logic [15:0] expPerf;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin
        IF_Req = 1'b1; IF_Addr = 32'h80;
        D_Req = 1'b1; D_Write = 1'b0; D_Addr = 32'h200;
      end
      if (c == 5) D_Req = 1'b0;
      if (c == 10) IF_Req = 1'b0;
      @(negedge Clock);
      checks++;
      if (D_Ack !== (c == 4) || IF_Ack !== (c == 9)) begin errors++;
        $display("FAIL cf_ack c=%0d got=%b%b", c, D_Ack, IF_Ack); end
      checks++;
      if (Mem_En !== (c == 1 || c == 6)) begin errors++;
        $display("FAIL cf_en c=%0d got=%b", c, Mem_En); end
      if (c == 1 || c == 6) begin
        checks++;
        if (Mem_Addr !== (c == 1 ? 32'h200 : 32'h80)) begin errors++;
          $display("FAIL cf_addr c=%0d got=%h", c, Mem_Addr); end
      end
      if (c == 4) begin
        checks++;
        if (D_RData !== memFn(32'h200)) begin errors++;
          $display("FAIL cf_drd got=%h exp=%h", D_RData, memFn(32'h200));
        end
      end
      if (c == 9) begin
        checks++;
        if (IF_RData !== memFn(32'h80)) begin errors++;
          $display("FAIL cf_ird got=%h exp=%h", IF_RData, memFn(32'h80));
        end
      end
      next_cycle();
    end
`ifdef MEM_ARB_PERF_CNT_EN
    expPerf = 16'd1;
`else
    expPerf = 16'd0;
`endif
    @(negedge Clock);
    checks++;
    if (Perf_Conflicts !== expPerf) begin errors++;
      $display("FAIL cf_perf got=%0d exp=%0d", Perf_Conflicts, expPerf); end
    next_cycle();
  endtask

  task automatic test_starve;
    do_reset();
    IF_Req = 1'b1; IF_Addr = 32'h300;
    D_Req = 1'b1; D_Write = 1'b0; D_Addr = 32'h400;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      checks++;
      if (D_Ack !== (c == 4 || c == 9 || c == 19)
          || IF_Ack !== (c == 14)) begin errors++;
        $display("FAIL sv_ack c=%0d got=%b%b", c, D_Ack, IF_Ack); end
      if (c == 14) begin
        checks++;
        if (IF_RData !== memFn(32'h300)) begin errors++;
          $display("FAIL sv_ird got=%h exp=%h", IF_RData, memFn(32'h300));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_wait;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin D_Req = 1'b1; D_Write = 1'b0; D_Addr = 32'h500; end
      if (c == 5) D_Req = 1'b0;
      next_cycle();
    end
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin D_Req = 1'b1; D_Addr = 32'h600; end
      if (c == 2) begin Reset = 1'b1; D_Req = 1'b0; end
      if (c == 3) Reset = 1'b0;
      if (c == 5) begin IF_Req = 1'b1; IF_Addr = 32'h700; end
      if (c == 10) IF_Req = 1'b0;
      @(negedge Clock);
      if (c == 3) begin
        checks++;
        if ({IF_Ack, D_Ack, Mem_En, Mem_We} !== 4'b0) begin errors++;
          $display("FAIL rw_flags got=%b exp=0",
            {IF_Ack, D_Ack, Mem_En, Mem_We}); end
        checks++;
        if ({IF_RData, D_RData, Mem_Addr, Mem_WData, Mem_ByteSel}
            !== '0) begin errors++;
          $display("FAIL rw_data got=%h %h %h %h", IF_RData, D_RData,
            Mem_Addr, Mem_WData); end
      end
      if (c >= 3) begin
        checks++;
        if (D_Ack !== 1'b0 || IF_Ack !== (c == 9)) begin errors++;
          $display("FAIL rw_ack c=%0d got=%b%b", c, D_Ack, IF_Ack); end
      end
      if (c == 6) begin
        checks++;
        if (Mem_En !== 1'b1 || Mem_Addr !== 32'h700) begin errors++;
          $display("FAIL rw_issue got=%b %h", Mem_En, Mem_Addr); end
      end
      if (c == 9) begin
        checks++;
        if (IF_RData !== memFn(32'h700)) begin errors++;
          $display("FAIL rw_ird got=%h exp=%h", IF_RData, memFn(32'h700));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_early_drop;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin IF_Req = 1'b1; IF_Addr = 32'h44; end
      if (c == 2) IF_Req = 1'b0;
      @(negedge Clock);
      checks++;
      if (IF_Ack !== (c == 4) || Mem_En !== (c == 1)) begin errors++;
        $display("FAIL ed_ack c=%0d got=%b%b", c, IF_Ack, Mem_En); end
      checks++;
      if (Stall_IF !== (c < 2)) begin errors++;
        $display("FAIL ed_stall c=%0d got=%b", c, Stall_IF); end
      next_cycle();
    end
  endtask

  task automatic test_random;
    int freeAt = 0;
    int issueAt = -1;
    int ackAt = -1;
    int starve = 0;
    int conf = 0;
    bit mOwnD = 1'b0;
    bit mWr = 1'b0;
    bit ifPend = 1'b0;
    bit dPend = 1'b0;
    bit expIfAck;
    bit expDAck;
    logic [31:0] mAddr = '0;
    logic [31:0] mWd = '0;
    logic [1:0]  mBs = '0;
    logic [31:0] expIf = '0;
    logic [31:0] expD = '0;
    logic [15:0] expPerf;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!ifPend && $urandom_range(0, 2) == 0) begin
        ifPend = 1'b1;
        IF_Addr = 32'($urandom_range(0, 255)) << 2;
      end
      IF_Req = ifPend;
      if (!dPend && $urandom_range(0, 2) == 0) begin
        dPend = 1'b1;
        D_Write = 1'($urandom_range(0, 1));
        D_Addr = 32'($urandom_range(0, 255)) << 2;
        D_WData = $urandom;
        D_ByteSel = 2'($urandom_range(0, 3));
      end
      D_Req = dPend;
      if (c >= freeAt && (IF_Req || D_Req)) begin
        if (IF_Req && D_Req) conf++;
        mOwnD = D_Req && !(IF_Req && starve == STARVE_MAX);
        if (mOwnD) begin
          if (IF_Req) starve++;
          mAddr = D_Addr; mWr = D_Write; mWd = D_WData; mBs = D_ByteSel;
        end else begin
          starve = 0;
          mAddr = IF_Addr; mWr = 1'b0;
        end
        issueAt = c + 1;
        ackAt = c + MEM_LAT + 2;
        freeAt = c + MEM_LAT + 3;
      end
      @(negedge Clock);
      expIfAck = (c == ackAt) && !mOwnD;
      expDAck = (c == ackAt) && mOwnD;
      if (expIfAck) expIf = memFn(mAddr);
      if (expDAck && !mWr) expD = memFn(mAddr);
      checks++;
      if (IF_Ack !== expIfAck || D_Ack !== expDAck) begin errors++;
        $display("FAIL rnd_ack c=%0d got=%b%b exp=%b%b", c, IF_Ack, D_Ack,
          expIfAck, expDAck); end
      checks++;
      if (Mem_En !== (c == issueAt)) begin errors++;
        $display("FAIL rnd_en c=%0d got=%b", c, Mem_En); end
      if (c == issueAt) begin
        checks++;
        if (Mem_We !== mWr || Mem_Addr !== mAddr) begin errors++;
          $display("FAIL rnd_issue c=%0d got=%b %h exp=%b %h", c, Mem_We,
            Mem_Addr, mWr, mAddr); end
        if (mWr) begin
          checks++;
          if (Mem_WData !== mWd || Mem_ByteSel !== mBs) begin errors++;
            $display("FAIL rnd_wr c=%0d got=%h %h exp=%h %h", c, Mem_WData,
              Mem_ByteSel, mWd, mBs); end
        end
      end
      checks++;
      if (IF_RData !== expIf || D_RData !== expD) begin errors++;
        $display("FAIL rnd_rdata c=%0d got=%h %h exp=%h %h", c, IF_RData,
          D_RData, expIf, expD); end
      checks++;
      if (Stall_IF !== (IF_Req && !expIfAck)
          || Stall_MEM !== (D_Req && !expDAck)) begin errors++;
        $display("FAIL rnd_stall c=%0d got=%b%b", c, Stall_IF, Stall_MEM);
      end
      if (IF_Ack) ifPend = 1'b0;
      if (D_Ack) dPend = 1'b0;
      next_cycle();
    end
`ifdef MEM_ARB_PERF_CNT_EN
    expPerf = 16'(conf);
`else
    expPerf = 16'd0;
`endif
    @(negedge Clock);
    checks++;
    if (Perf_Conflicts !== expPerf) begin errors++;
      $display("FAIL rnd_perf got=%0d exp=%0d", Perf_Conflicts, expPerf); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_store();
    test_conflict();
    test_starve();
    test_reset_wait();
    test_early_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
